prefix_addsub_pipe: RTL

- 3-stage pipelined 64-bit parallel-prefix (Kogge-Stone) adder/subtractor for the Y86 ALU execute path.
- The existing prefix cells reduce operand bits into group propagate/generate. This block is the consuming end: it registers the prefix tree and resolves carries back into sum bits and Y86 condition codes.
- Sits between operand select and the CC register / valE write path.
- Uses a valid/ready handshake so the pipelined core can stall it.

---
 rtl/prefix_addsub_pipe.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/prefix_addsub_pipe.sv
// Three-stage Kogge-Stone adder/subtractor with valid/ready flow control and Y86 flags.
// Define PREFIX_ADDSUB_CC_EN to build the cout/zf/sf/of flag path; otherwise the flags read 0.
module prefix_addsub_pipe #(
  parameter int W     = 64,
  parameter int SPLIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_zf,
  output logic         out_sf,
  output logic         out_of
);
  localparam int L  = $clog2(W);
  localparam int L3 = L - SPLIT;

  // One Kogge-Stone level at distance 2**lvl; low positions pass through unchanged.
  function automatic logic [W-1:0] ks_g(input logic [W-1:0] g, input logic [W-1:0] p, input int lvl);
    return g | (p & (g << (1 << lvl)));
  endfunction

  function automatic logic [W-1:0] ks_p(input logic [W-1:0] p, input int lvl);
    return p & ((p << (1 << lvl)) | ~({W{1'b1}} << (1 << lvl)));
  endfunction

  logic         r_v1, r_v2, r_v3;
  logic [W-1:0] r_p1, r_g1, r_hs2, r_g2, r_pg2, r_sum;
  logic         r_cin1, r_cin2;
  logic         w_s1_load, w_s2_load, w_s3_load;
  logic [W-1:0] w_b_eff;
  logic [W-1:0] w_g_s2 [0:SPLIT];
  logic [W-1:0] w_p_s2 [0:SPLIT];
  logic [W-1:0] w_g_s3 [0:L3];
  logic [W-1:0] w_p_s3 [0:L3];
  logic [W:0]   w_carry;
  logic [W-1:0] w_sum;
  logic         w_unused;

  assign w_s3_load = !r_v3 || out_ready;
  assign w_s2_load = !r_v2 || w_s3_load;
  assign w_s1_load = !r_v1 || w_s2_load;
  assign in_ready  = w_s1_load;
  assign out_valid = r_v3;
  assign out_sum   = r_sum;

  assign w_b_eff = in_sub ? ~in_b : in_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_p1   <= '0;
      r_g1   <= '0;
      r_cin1 <= 1'b0;
    end else if (w_s1_load) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_p1   <= in_a ^ w_b_eff;
        r_g1   <= in_a & w_b_eff;
        r_cin1 <= in_sub;
      end
    end
  end

  // Carry-in enters as the generate of a virtual bit -1, merged into bit 0.
  assign w_p_s2[0] = r_p1;
  assign w_g_s2[0] = r_g1 | {{(W-1){1'b0}}, r_p1[0] & r_cin1};

  genvar gi;
  generate
    for (gi = 0; gi < SPLIT; gi++) begin : g_lvl_s2
      assign w_g_s2[gi+1] = ks_g(w_g_s2[gi], w_p_s2[gi], gi);
      assign w_p_s2[gi+1] = ks_p(w_p_s2[gi], gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_g2   <= '0;
      r_pg2  <= '0;
      r_hs2  <= '0;
      r_cin2 <= 1'b0;
    end else if (w_s2_load) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_g2   <= w_g_s2[SPLIT];
        r_pg2  <= w_p_s2[SPLIT];
        r_hs2  <= r_p1;
        r_cin2 <= r_cin1;
      end
    end
  end

  assign w_g_s3[0] = r_g2;
  assign w_p_s3[0] = r_pg2;

  generate
    for (gi = 0; gi < L3; gi++) begin : g_lvl_s3
      assign w_g_s3[gi+1] = ks_g(w_g_s3[gi], w_p_s3[gi], SPLIT + gi);
      assign w_p_s3[gi+1] = ks_p(w_p_s3[gi], SPLIT + gi);
    end
  endgenerate

  assign w_carry = {w_g_s3[L3], r_cin2};
  assign w_sum   = r_hs2 ^ w_carry[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3  <= 1'b0;
      r_sum <= '0;
    end else if (w_s3_load) begin
      r_v3 <= r_v2;
      if (r_v2) r_sum <= w_sum;
    end
  end

`ifdef PREFIX_ADDSUB_CC_EN
  logic r_amsb1, r_bmsb1, r_amsb2, r_bmsb2;
  logic r_cout, r_zf, r_sf, r_of;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_amsb1 <= 1'b0;
      r_bmsb1 <= 1'b0;
      r_amsb2 <= 1'b0;
      r_bmsb2 <= 1'b0;
      r_cout  <= 1'b0;
      r_zf    <= 1'b0;
      r_sf    <= 1'b0;
      r_of    <= 1'b0;
    end else begin
      if (w_s1_load && in_valid) begin
        r_amsb1 <= in_a[W-1];
        r_bmsb1 <= w_b_eff[W-1];
      end
      if (w_s2_load && r_v1) begin
        r_amsb2 <= r_amsb1;
        r_bmsb2 <= r_bmsb1;
      end
      // Using the inverted B operand lets one overflow rule cover add and subtract.
      if (w_s3_load && r_v2) begin
        r_cout <= w_carry[W];
        r_zf   <= ~|w_sum;
        r_sf   <= w_sum[W-1];
        r_of   <= (r_amsb2 == r_bmsb2) && (w_sum[W-1] != r_amsb2);
      end
    end
  end

  assign out_cout = r_cout;
  assign out_zf   = r_zf;
  assign out_sf   = r_sf;
  assign out_of   = r_of;
  assign w_unused = ^w_p_s3[L3];
`else
  assign out_cout = 1'b0;
  assign out_zf   = 1'b0;
  assign out_sf   = 1'b0;
  assign out_of   = 1'b0;
  assign w_unused = ^{w_p_s3[L3], w_carry[W]};
`endif

endmodule
